// File: rtl/calc_display_pkg.sv
// Shared constants for the calculator front-panel display.
// Contents: active-high 7-segment codes {g,f,e,d,c,b,a} for hex digits,
// the all-segments-off pin pattern, scan timing defaults and the slot enum.
package calc_display_pkg;

  localparam logic [6:0] SEG_HEX_0 = 7'h3F;
  localparam logic [6:0] SEG_HEX_1 = 7'h06;
  localparam logic [6:0] SEG_HEX_2 = 7'h5B;
  localparam logic [6:0] SEG_HEX_3 = 7'h4F;
  localparam logic [6:0] SEG_HEX_4 = 7'h66;
  localparam logic [6:0] SEG_HEX_5 = 7'h6D;
  localparam logic [6:0] SEG_HEX_6 = 7'h7D;
  localparam logic [6:0] SEG_HEX_7 = 7'h07;
  localparam logic [6:0] SEG_HEX_8 = 7'h7F;
  localparam logic [6:0] SEG_HEX_9 = 7'h6F;
  localparam logic [6:0] SEG_HEX_A = 7'h77;
  localparam logic [6:0] SEG_HEX_B = 7'h7C;
  localparam logic [6:0] SEG_HEX_C = 7'h39;
  localparam logic [6:0] SEG_HEX_D = 7'h5E;
  localparam logic [6:0] SEG_HEX_E = 7'h79;
  localparam logic [6:0] SEG_HEX_F = 7'h71;

  // Active-low pin pattern with every segment dark.
  localparam logic [6:0] SEG_OFF = 7'h7F;

  localparam int unsigned DEFAULT_DIGITS       = 4;
  localparam int unsigned DEFAULT_PRESCALE     = 1000;
  localparam int unsigned DEFAULT_BLANK_CYCLES = 16;

  // Phase within a digit slot: anti-ghosting blank, then digit lit.
  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_ON    = 1'b1
  } slot_e;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-high 7-segment code.
// Ports: nibble (4-bit hex digit in), seg_c (7-bit {g,f,e,d,c,b,a} code out).
module hex_to_seg7
  import calc_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_HEX_0;
    case (nibble)
      4'h0: seg_c = SEG_HEX_0;
      4'h1: seg_c = SEG_HEX_1;
      4'h2: seg_c = SEG_HEX_2;
      4'h3: seg_c = SEG_HEX_3;
      4'h4: seg_c = SEG_HEX_4;
      4'h5: seg_c = SEG_HEX_5;
      4'h6: seg_c = SEG_HEX_6;
      4'h7: seg_c = SEG_HEX_7;
      4'h8: seg_c = SEG_HEX_8;
      4'h9: seg_c = SEG_HEX_9;
      4'hA: seg_c = SEG_HEX_A;
      4'hB: seg_c = SEG_HEX_B;
      4'hC: seg_c = SEG_HEX_C;
      4'hD: seg_c = SEG_HEX_D;
      4'hE: seg_c = SEG_HEX_E;
      4'hF: seg_c = SEG_HEX_F;
      default: seg_c = SEG_HEX_0;
    endcase
  end

endmodule

// File: rtl/display_scanner.sv
// Multiplexed 7-segment scanner with double-buffered display value.
// Ports:
//   clock, reset       - system clock, synchronous active-high reset
//   load               - strobe capturing value/dp_mask into the pending buffer
//   value, dp_mask     - hex nibbles (digit 0 = LSB) and per-digit decimal points
//   blank_lz           - live leading-zero blanking enable
//   seg, dp, digit_sel - active-low segment, decimal point and digit enables
//   frame_start        - one-cycle pulse at each frame boundary
module display_scanner
  import calc_display_pkg::*;
#(
  parameter int unsigned DIGITS       = DEFAULT_DIGITS,
  parameter int unsigned PRESCALE     = DEFAULT_PRESCALE,
  parameter int unsigned BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_start
);

  localparam int unsigned IDX_W = $clog2(DIGITS);
  localparam int unsigned PS_W  = $clog2(PRESCALE);
  localparam int unsigned VAL_W = 4 * DIGITS;

  logic [PS_W-1:0]   prescaler_q, prescaler_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [VAL_W-1:0]  active_value_q, active_value_d;
  logic [DIGITS-1:0] active_dp_q, active_dp_d;
  logic [VAL_W-1:0]  pending_value_q, pending_value_d;
  logic [DIGITS-1:0] pending_dp_q, pending_dp_d;
  logic              pending_valid_q, pending_valid_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [DIGITS-1:0] digit_sel_q, digit_sel_d;
  logic              frame_start_q, frame_start_d;

  logic              frame_boundary_c;
  slot_e             slot_c;
  logic [3:0]        nibble_c;
  logic              dp_sel_c;
  logic              zero_run_c;
  logic              lz_blank_c;
  logic [6:0]        code_c;

  assign frame_boundary_c = (prescaler_q == '0) && (idx_q == '0);

  // Slot timing: prescaler wraps at PRESCALE-1, advancing the digit index.
  always_comb begin
    prescaler_d = prescaler_q + PS_W'(1);
    idx_d       = idx_q;
    if (prescaler_q == PS_W'(PRESCALE - 1)) begin
      prescaler_d = '0;
      idx_d       = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Double buffer: active only changes at a frame boundary; a load landing
  // on the boundary itself goes straight to active and supersedes pending.
  always_comb begin
    active_value_d  = active_value_q;
    active_dp_d     = active_dp_q;
    pending_value_d = pending_value_q;
    pending_dp_d    = pending_dp_q;
    pending_valid_d = pending_valid_q;
    if (frame_boundary_c) begin
      if (load) begin
        active_value_d  = value;
        active_dp_d     = dp_mask;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        active_value_d  = pending_value_q;
        active_dp_d     = pending_dp_q;
        pending_valid_d = 1'b0;
      end
    end else if (load) begin
      pending_value_d = value;
      pending_dp_d    = dp_mask;
      pending_valid_d = 1'b1;
    end
  end

  // Digit data is taken from the next-active view so the boundary cycle
  // already shows the new frame even if no blank cycles are configured.
  always_comb begin
    nibble_c = '0;
    dp_sel_c = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nibble_c = active_value_d[4*i +: 4];
        dp_sel_c = active_dp_d[i];
      end
    end
  end

  // Leading-zero blank: walk down from the top digit while nibbles stay zero.
  always_comb begin
    zero_run_c = 1'b1;
    lz_blank_c = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zero_run_c = zero_run_c && (active_value_d[4*i +: 4] == 4'h0);
      if (idx_q == IDX_W'(i)) begin
        lz_blank_c = blank_lz && zero_run_c;
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (nibble_c),
    .seg_c  (code_c)
  );

  assign slot_c = (prescaler_q < PS_W'(BLANK_CYCLES)) ? SLOT_BLANK : SLOT_ON;

  // Pin values for the next cycle from the current slot phase.
  always_comb begin
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    digit_sel_d   = '1;
    frame_start_d = frame_boundary_c;
    if (slot_c == SLOT_ON) begin
      digit_sel_d = ~(DIGITS'(1) << idx_q);
      seg_d       = lz_blank_c ? SEG_OFF : ~code_c;
      dp_d        = ~dp_sel_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler_q     <= '0;
      idx_q           <= '0;
      active_value_q  <= '0;
      active_dp_q     <= '0;
      pending_value_q <= '0;
      pending_dp_q    <= '0;
      pending_valid_q <= 1'b0;
      seg_q           <= SEG_OFF;
      dp_q            <= 1'b1;
      digit_sel_q     <= '1;
      frame_start_q   <= 1'b0;
    end else begin
      prescaler_q     <= prescaler_d;
      idx_q           <= idx_d;
      active_value_q  <= active_value_d;
      active_dp_q     <= active_dp_d;
      pending_value_q <= pending_value_d;
      pending_dp_q    <= pending_dp_d;
      pending_valid_q <= pending_valid_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      digit_sel_q     <= digit_sel_d;
      frame_start_q   <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign digit_sel   = digit_sel_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_display_scanner.sv
// Self-checking bench for display_scanner (DIGITS=4, PRESCALE=4, BLANK_CYCLES=1).
// Expected per-slot pin values are pushed to a scoreboard queue from a small
// reference decode when a value is loaded, and popped as each slot is scanned.
module tb_display_scanner;

  localparam int unsigned DIGITS = 4;

  localparam logic [6:0] CODES [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [3:0] sel;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp_mask;
  logic        blank_lz;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  digit_sel;
  logic        frame_start;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  display_scanner #(
    .DIGITS       (4),
    .PRESCALE     (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .load        (load),
    .value       (value),
    .dp_mask     (dp_mask),
    .blank_lz    (blank_lz),
    .seg         (seg),
    .dp          (dp),
    .digit_sel   (digit_sel),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  // Reference expectation for one displayed frame.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] m, input logic lz);
    exp_t e;
    logic [15:0] upper;
    for (int d = 0; d < DIGITS; d++) begin
      upper = v >> (4 * d);
      e.sel = ~(4'b0001 << d);
      e.dp  = ~m[d];
      if (lz && d > 0 && upper == 16'h0) e.seg = 7'h7F;
      else e.seg = ~CODES[v[4*d +: 4]];
      sb_q.push_back(e);
    end
  endtask

  // Strobe load for one cycle, placed mid-frame.
  task automatic load_now(input logic [15:0] v, input logic [3:0] m);
    @(negedge clock);
    @(negedge clock);
    load    = 1'b1;
    value   = v;
    dp_mask = m;
  endtask

  // Wait for a frame_start, then check all 16 cycles of the frame.
  // Optional loads: mid_a at pos1, mid_b at pos2, edge_val on the next boundary.
  task automatic check_frame(input string name, input int max_wait,
                             input bit mid_en, input logic [15:0] mid_a,
                             input logic [15:0] mid_b, input bit edge_en,
                             input logic [15:0] edge_val, output int waited);
    bit   found;
    exp_t e;
    exp_t want;
    logic fs_want;
    waited = 0;
    found  = 1'b0;
    while (!found && waited < max_wait) begin
      @(negedge clock);
      load = 1'b0;
      waited++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s frame_start timeout: got none after %0d cycles, want a pulse", name, waited);
      for (int k = 0; k < DIGITS && sb_q.size() > 0; k++) void'(sb_q.pop_front());
      return;
    end
    e = '{sel: 4'hF, seg: 7'h7F, dp: 1'b1};
    for (int pos = 0; pos < 16; pos++) begin
      if (pos > 0) begin
        @(negedge clock);
        load = 1'b0;
      end
      fs_want = (pos == 0);
      if (pos % 4 == 0) begin
        want = '{sel: 4'hF, seg: 7'h7F, dp: 1'b1};
      end else begin
        if (pos % 4 == 1) begin
          if (sb_q.size() > 0) e = sb_q.pop_front();
          else begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty: got no entry, want one per slot", name);
          end
        end
        want = e;
      end
      checks++;
      if ({digit_sel, seg, dp, frame_start} !== {want.sel, want.seg, want.dp, fs_want}) begin
        errors++;
        $display("FAIL %s pos%0d: got sel=%b seg=%h dp=%b fs=%b, want sel=%b seg=%h dp=%b fs=%b",
                 name, pos, digit_sel, seg, dp, frame_start, want.sel, want.seg, want.dp, fs_want);
      end
      if (mid_en && pos == 1) begin
        load = 1'b1; value = mid_a; dp_mask = 4'h0;
      end
      if (mid_en && pos == 2) begin
        load = 1'b1; value = mid_b; dp_mask = 4'h0;
      end
      if (edge_en && pos == 15) begin
        load = 1'b1; value = edge_val; dp_mask = 4'h0;
      end
    end
  endtask

  task automatic check_idle(input string name);
    checks++;
    if ({digit_sel, seg, dp, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL %s: got sel=%b seg=%h dp=%b fs=%b, want sel=1111 seg=7f dp=1 fs=0",
               name, digit_sel, seg, dp, frame_start);
    end
  endtask

  task automatic test_reset();
    int w;
    reset = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check_idle("reset_hold");
    end
    reset = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b0);
    check_frame("reset_first_frame", 4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL reset_first_pulse: got pulse after %0d cycles, want 1", w);
    end
  endtask

  task automatic test_decode();
    int w;
    load_now(16'h12AF, 4'b0010);
    push_frame(16'h12AF, 4'b0010, 1'b0);
    check_frame("decode_12AF", 40, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
  endtask

  task automatic test_all_codes();
    int w;
    logic [15:0] vals [4] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC};
    for (int k = 0; k < 4; k++) begin
      load_now(vals[k], 4'(k * 5));
      push_frame(vals[k], 4'(k * 5), 1'b0);
      check_frame("all_codes", 40, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
    end
  endtask

  task automatic test_leading_zero();
    int w;
    logic [15:0] vals  [3] = '{16'h0005, 16'h0000, 16'h0105};
    logic [3:0]  masks [3] = '{4'b0000, 4'b1000, 4'b0000};
    blank_lz = 1'b1;
    for (int k = 0; k < 3; k++) begin
      load_now(vals[k], masks[k]);
      push_frame(vals[k], masks[k], 1'b1);
      check_frame("leading_zero", 40, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    push_frame(16'h0105, 4'h0, 1'b0);
    check_frame("midframe_hold", 40, 1'b1, 16'h1111, 16'h2222, 1'b0, 16'h0, w);
    push_frame(16'h2222, 4'h0, 1'b0);
    check_frame("last_write_wins", 4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
  endtask

  task automatic test_boundary_bypass();
    int w;
    push_frame(16'h2222, 4'h0, 1'b0);
    check_frame("pre_bypass", 40, 1'b1, 16'h3333, 16'h3333, 1'b1, 16'hEEEE, w);
    push_frame(16'hEEEE, 4'h0, 1'b0);
    check_frame("bypass_frame", 4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL bypass_next_frame: got pulse after %0d cycles, want 1", w);
    end
    push_frame(16'hEEEE, 4'h0, 1'b0);
    check_frame("pending_cleared", 4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
  endtask

  task automatic test_reset_mid_slot();
    int  w;
    bit  found;
    found = 1'b0;
    w     = 0;
    while (!found && w < 40) begin
      @(negedge clock);
      w++;
      if (frame_start === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_sync: got no frame_start in %0d cycles, want a pulse", w);
    end
    repeat (9) @(negedge clock);
    checks++;
    if ({digit_sel, seg} !== {4'b1011, 7'h06}) begin
      errors++;
      $display("FAIL digit2_on: got sel=%b seg=%h, want sel=1011 seg=06", digit_sel, seg);
    end
    reset = 1'b1;
    @(negedge clock);
    check_idle("reset_mid_slot");
    @(negedge clock);
    check_idle("reset_mid_hold");
    reset = 1'b0;
    push_frame(16'h0000, 4'h0, 1'b0);
    check_frame("post_reset_frame", 4, 1'b0, 16'h0, 16'h0, 1'b0, 16'h0, w);
    checks++;
    if (w != 1) begin
      errors++;
      $display("FAIL post_reset_pulse: got pulse after %0d cycles, want 1", w);
    end
  endtask

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    value    = 16'h0;
    dp_mask  = 4'h0;
    blank_lz = 1'b0;
    test_reset();
    test_decode();
    test_all_codes();
    test_leading_zero();
    test_back_to_back();
    test_boundary_bypass();
    test_reset_mid_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
